// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: FSM states,
// condition-code encodings and NZCV flag bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational condition-code evaluation against the NZCV flags.
module alu_cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !(c && !z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = !(!z && (n == v));
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Three-cycle issue stage: register-file read, external ALU execute, write-back.
// Define ALU_ISSUE_COND_EN to enable conditional execution; otherwise every instruction runs as AL.
//
// state   | meaning
// IDLE    | ready; capture instruction and operands on handshake
// EXEC    | operands held on port_A/port_B; ALU result registered at end
// WB      | condition check, register write, wb_valid pulse, flag update
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_OP,
    input  logic [3:0]  in_cmd,
    input  logic [3:0]  in_cond,
    input  logic        in_S,
    input  logic        in_wen,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rm,
    input  logic        in_imm_sel,
    input  logic [31:0] in_imm,
    output logic [31:0] port_A,
    output logic [31:0] port_B,
    output logic [3:0]  cmd,
    output logic [1:0]  OP,
    input  logic [31:0] ALU_output,
    input  logic [3:0]  ALU_Flags,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  flags_q,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      state_q, state_d;
    logic [31:0] regs [16];
    logic [3:0]  rd_q;
    logic        s_q;
    logic        wen_q;
    logic [31:0] res_q;
    logic [3:0]  alu_flags_q;
    logic [3:0]  cond_eff;
    logic        cond_pass;
    logic        accept;
    logic        commit;

    assign accept   = in_valid && in_ready;
    assign commit   = (state_q == ST_WB) && cond_pass;
    assign wb_valid = commit && wen_q;
    assign wb_rd    = rd_q;
    assign wb_data  = res_q;
    assign dbg_data = regs[dbg_addr];

`ifdef ALU_ISSUE_COND_EN
    logic [3:0] cond_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q <= COND_AL;
        end else if (accept) begin
            cond_q <= in_cond;
        end
    end

    assign cond_eff = cond_q;
`else
    logic unused_cond;
    assign unused_cond = ^in_cond;
    assign cond_eff    = COND_AL;
`endif

    // Evaluated against flags_q before this instruction's own flag update.
    alu_cond_check u_cond_check (
        .cond  (cond_eff),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_A      <= '0;
            port_B      <= '0;
            cmd         <= '0;
            OP          <= '0;
            rd_q        <= '0;
            s_q         <= 1'b0;
            wen_q       <= 1'b0;
            res_q       <= '0;
            alu_flags_q <= '0;
            flags_q     <= RST_FLAGS;
        end else begin
            if (accept) begin
                port_A <= regs[in_rn];
                port_B <= in_imm_sel ? in_imm : regs[in_rm];
                cmd    <= in_cmd;
                OP     <= in_OP;
                rd_q   <= in_rd;
                s_q    <= in_S;
                wen_q  <= in_wen;
            end
            if (state_q == ST_EXEC) begin
                res_q       <= ALU_output;
                alu_flags_q <= ALU_Flags;
            end
            if (commit && s_q) begin
                flags_q <= alu_flags_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (commit && wen_q) begin
            regs[rd_q] <= res_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with an adder ALU stub (cmd 4 = add).
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_OP = '0;
    logic [3:0]  in_cmd = '0;
    logic [3:0]  in_cond = COND_AL;
    logic        in_S = 1'b0;
    logic        in_wen = 1'b0;
    logic [3:0]  in_rd = '0, in_rn = '0, in_rm = '0;
    logic        in_imm_sel = 1'b0;
    logic [31:0] in_imm = '0;
    logic [31:0] port_A, port_B;
    logic [3:0]  cmd;
    logic [1:0]  OP;
    logic [31:0] ALU_output;
    logic [3:0]  ALU_Flags;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags_q;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.RST_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_OP(in_OP), .in_cmd(in_cmd), .in_cond(in_cond), .in_S(in_S), .in_wen(in_wen),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm_sel(in_imm_sel), .in_imm(in_imm),
        .port_A(port_A), .port_B(port_B), .cmd(cmd), .OP(OP),
        .ALU_output(ALU_output), .ALU_Flags(ALU_Flags),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags_q(flags_q),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stub: add with NZCV; other commands pass port_B through
    logic [32:0] sum;
    always_comb begin
        sum        = {1'b0, port_A} + {1'b0, port_B};
        ALU_output = port_B;
        ALU_Flags  = 4'b0000;
        if (cmd == 4'd4) begin
            ALU_output = sum[31:0];
            ALU_Flags  = {sum[31], (sum[31:0] == 32'h0), sum[32],
                          (port_A[31] == port_B[31]) && (sum[31] != port_A[31])};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    // Drives one instruction and returns #1 after the accepting edge (cycle in EXEC).
    task automatic send(input logic [3:0] rd, input logic [3:0] rn, input logic [31:0] imm,
                        input logic [3:0] cond, input logic s, input logic wen, input logic [1:0] op);
        bit got;
        @(negedge clk);
        in_rd = rd; in_rn = rn; in_rm = 4'd0; in_imm_sel = 1'b1; in_imm = imm;
        in_cond = cond; in_S = s; in_wen = wen; in_OP = op; in_cmd = 4'd4;
        in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL send_handshake: in_ready=%b after 20 cycles, wanted 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", flags_q); end
        total++; if ({port_A, port_B} !== 64'h0) begin bad++; $display("FAIL rst_ports: got %h %h want 0 0", port_A, port_B); end
        total++; if ({cmd, OP, wb_rd} !== 10'h0) begin bad++; $display("FAIL rst_cmd_op_rd: got %h %h %h want 0", cmd, OP, wb_rd); end
        total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0", i, dbg_data); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load;
        send(4'd1, 4'd0, 32'h0001_1111, COND_AL, 1'b0, 1'b1, 2'd0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_exec_ready: got %b want 0", in_ready); end
        total++; if (port_A !== 32'h0 || port_B !== 32'h0001_1111) begin bad++; $display("FAIL load_ports: got %h %h want 0 00011111", port_A, port_B); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_exec_wb: got %b want 0", wb_valid); end
        step();
        total++; if (wb_valid !== 1'b1 || wb_rd !== 4'd1 || wb_data !== 32'h0001_1111) begin
            bad++; $display("FAIL load_wb: got v=%b rd=%0d d=%h want 1 1 00011111", wb_valid, wb_rd, wb_data); end
        step();
        dbg_addr = 4'd1; #1;
        total++; if (dbg_data !== 32'h0001_1111) begin bad++; $display("FAIL load_r1: got %h want 00011111", dbg_data); end
        total++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL load_idle: got v=%b rdy=%b want 0 1", wb_valid, in_ready); end
    endtask

    task automatic test_back_to_back;
        send(4'd2, 4'd1, 32'h1, COND_AL, 1'b1, 1'b1, 2'd0);
        total++; if (port_A !== 32'h0001_1111) begin bad++; $display("FAIL b2b_portA: got %h want 00011111", port_A); end
        step();
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0001_1112) begin bad++; $display("FAIL b2b_wb: got v=%b d=%h want 1 00011112", wb_valid, wb_data); end
        step();
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL b2b_flags: got %b want 0000", flags_q); end
    endtask

    task automatic test_flags;
        send(4'd3, 4'd0, 32'hFFFF_FFFF, COND_AL, 1'b0, 1'b1, 2'd0);
        step(); step();
        send(4'd4, 4'd3, 32'h1, COND_AL, 1'b1, 1'b1, 2'd0);
        step();
        total++; if (wb_valid !== 1'b1 || wb_rd !== 4'd4 || wb_data !== 32'h0) begin
            bad++; $display("FAIL flags_wb: got v=%b rd=%0d d=%h want 1 4 0", wb_valid, wb_rd, wb_data); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL flags_pre_update: got %b want 0000", flags_q); end
        step();
        total++; if (flags_q !== 4'b0110) begin bad++; $display("FAIL flags_post: got %b want 0110", flags_q); end
    endtask

    task automatic test_cond;
        logic       exp_v;
        logic [31:0] exp_r5;
        logic [3:0]  exp_f;
`ifdef ALU_ISSUE_COND_EN
        exp_v = 1'b0; exp_r5 = 32'h0; exp_f = 4'b0110;
`else
        exp_v = 1'b1; exp_r5 = 32'h55; exp_f = 4'b0000;
`endif
        send(4'd5, 4'd0, 32'h55, COND_NE, 1'b1, 1'b1, 2'd0);
        step();
        total++; if (wb_valid !== exp_v) begin bad++; $display("FAIL cond_ne_wb: got %b want %b", wb_valid, exp_v); end
        step();
        dbg_addr = 4'd5; #1;
        total++; if (dbg_data !== exp_r5) begin bad++; $display("FAIL cond_ne_r5: got %h want %h", dbg_data, exp_r5); end
        total++; if (flags_q !== exp_f) begin bad++; $display("FAIL cond_ne_flags: got %b want %b", flags_q, exp_f); end
        send(4'd5, 4'd0, 32'h66, COND_EQ, 1'b0, 1'b1, 2'd0);
        step();
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'h66) begin bad++; $display("FAIL cond_eq_wb: got v=%b d=%h want 1 66", wb_valid, wb_data); end
        step();
        #1;
        total++; if (dbg_data !== 32'h66) begin bad++; $display("FAIL cond_eq_r5: got %h want 66", dbg_data); end
    endtask

    task automatic test_op3_nowen;
        send(4'd7, 4'd1, 32'h2, COND_AL, 1'b0, 1'b0, 2'd3);
        total++; if (OP !== 2'd3 || cmd !== 4'd4) begin bad++; $display("FAIL op3_fwd: got OP=%0d cmd=%0d want 3 4", OP, cmd); end
        step();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL nowen_wb: got %b want 0", wb_valid); end
        step();
        dbg_addr = 4'd7; #1;
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL nowen_r7: got %h want 0", dbg_data); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        send(4'd8, 4'd3, 32'h1, COND_AL, 1'b1, 1'b0, 2'd0);
        step(); step();
        total++; if (flags_q !== 4'b0110) begin bad++; $display("FAIL rmid_pre_flags: got %b want 0110", flags_q); end
        send(4'd6, 4'd0, 32'h66, COND_AL, 1'b1, 1'b1, 2'd0);
        rst_n = 1'b0;
        #2;
        total++; if (flags_q !== 4'b0000 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_async: got f=%b rdy=%b want 0000 1", flags_q, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (wb_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_wb_pulses: got %0d want 0", pulses); end
        dbg_addr = 4'd6; #1;
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL rmid_r6: got %h want 0", dbg_data); end
        dbg_addr = 4'd1; #1;
        total++; if (dbg_data !== 32'h0) begin bad++; $display("FAIL rmid_r1_cleared: got %h want 0", dbg_data); end
        total++; if (in_ready !== 1'b1 || flags_q !== 4'b0000) begin bad++; $display("FAIL rmid_post: got rdy=%b f=%b want 1 0000", in_ready, flags_q); end
    endtask

    task automatic test_busy;
        logic [5:0] rdy_seq, wb_seq;
        @(negedge clk);
        in_rd = 4'd9; in_rn = 4'd0; in_imm_sel = 1'b1; in_imm = 32'h5;
        in_cond = COND_AL; in_S = 1'b0; in_wen = 1'b1; in_OP = 2'd0; in_cmd = 4'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            rdy_seq[5-i] = in_ready;
            wb_seq[5-i]  = wb_valid;
        end
        in_valid = 1'b0;
        total++; if (rdy_seq !== 6'b001001) begin bad++; $display("FAIL busy_ready_seq: got %b want 001001", rdy_seq); end
        total++; if (wb_seq !== 6'b010010) begin bad++; $display("FAIL busy_wb_seq: got %b want 010010", wb_seq); end
        dbg_addr = 4'd9; #1;
        total++; if (dbg_data !== 32'h5) begin bad++; $display("FAIL busy_r9: got %h want 5", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_flags();
        test_cond();
        test_op3_nowen();
        test_reset_mid();
        test_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: RST_FLAGS, 4'b0000, reset value of flags_q.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: in_valid  in  1; in_ready  out  1; instruction handshake.
REQ-005 SHALL have ports: in_OP  in  2; in_cmd  in  4; in_cond  in  4; in_S  in  1 (set flags); in_wen  in  1 (write rd).
REQ-006 SHALL have ports: in_rd, in_rn, in_rm  in  4 each; in_imm_sel  in  1; in_imm  in  32.
REQ-007 SHALL have ALU-side ports: port_A, port_B  out  32; cmd  out  4; OP  out  2; ALU_output  in  32; ALU_Flags  in  4 ({N,Z,C,V}).
REQ-008 SHALL have ports: wb_valid  out  1; wb_rd  out  4; wb_data  out  32; flags_q  out  4; dbg_addr  in  4; dbg_data  out  32.

Function
REQ-009 SHALL contain a 16x32 register file; dbg_data = reg[dbg_addr], combinational.
REQ-010 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; in_ready = 1 only in IDLE.
REQ-011 IDLE: on in_valid & in_ready, SHALL latch all in_* fields, port_A <= reg[in_rn], port_B <= in_imm_sel ? in_imm : reg[in_rm], cmd/OP <= in_cmd/in_OP; go EXEC.
REQ-012 EXEC: SHALL hold ALU inputs stable for one cycle and register ALU_output/ALU_Flags at its end; go WB.
REQ-013 WB: SHALL evaluate the latched cond against flags_q (pre-update); if passed: write reg[rd] when wen, pulse wb_valid=1 for one cycle with wb_rd/wb_data when wen, load flags_q from ALU_Flags when S; go IDLE.
REQ-014 Cond codes: 0 EQ Z; 1 NE; 2 CS C; 3 CC; 4 MI N; 5 PL; 6 VS V; 7 VC; 8 HI C&!Z; 9 LS; 10 GE N==V; 11 LT; 12 GT !Z&(N==V); 13 LE; 14 AL; 15 NV never.
REQ-015 Failed condition SHALL suppress register write, wb_valid and flag update; FSM timing unchanged.
REQ-016 Latency: accept at edge t, wb_valid high during cycle t+2; throughput one instruction per 3 cycles.
REQ-017 Because acceptance only occurs in IDLE, a following instruction SHALL read the already-written value (no hazard logic).
REQ-018 in_OP = 3 SHALL be accepted and forwarded unchanged; the block does not filter it.
REQ-019 in_valid while not IDLE SHALL be ignored; the sender holds fields until handshake.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, all 16 registers 0, flags_q = RST_FLAGS, wb_valid 0, wb_rd 0, wb_data 0, port_A/port_B 0, cmd/OP 0.
REQ-021 Reset mid-EXEC or mid-WB SHALL discard the instruction with no write or flag update; no capture while rst_n low.

Configuration
REQ-022 With ALU_ISSUE_COND_EN defined, REQ-014/015 apply; without it, in_cond is ignored and every instruction executes as AL.

Structure
REQ-023 Shared package alu_pkg SHALL hold FSM state enum, cond-code constants, flag bit indices (N=3, Z=2, C=1, V=0).
REQ-024 Condition evaluation SHALL be sub-module alu_cond_check (cond, flags -> pass).

Verification (bench ALU stub: cmd 4 = add, NZCV from 32-bit add)
REQ-025 Reset then load r1 = r0 + imm 0x11111, wen=1 -> wb_valid in cycle t+2, wb_rd=1, wb_data=0x00011111, dbg r1 = 0x00011111.
REQ-026 r2 = r1 + imm 1 with S=1 issued immediately after -> wb_data=0x00011112, flags_q=0000.
REQ-027 r3 = r0 + imm 0xFFFFFFFF then r4 = r3 + imm 1, S=1 -> wb_data=0, flags_q Z=1, C=1 (0110).
REQ-028 Then cond=NE instruction writing r5 -> no wb_valid, r5 stays 0, flags_q unchanged; cond=EQ writes r5.
REQ-029 rst_n low during EXEC of r6 write -> r6 = 0, flags_q = RST_FLAGS, in_ready=1 after release.
REQ-030 in_valid held high while busy -> exactly one capture per handshake, in_ready low in EXEC and WB.
